spi_reg_seq: RTL and testbench
==============================

SPI_REG_SEQ -- requirements
Module: spi_reg_seq

Interface
REQ-001 SHALL have parameter CS_SETUP, default 4, meaning clocks between O_cs falling and the first byte launch.
REQ-002 SHALL have parameter CS_HOLD, default 4, meaning clocks between the last byte done and O_cs rising.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning maximum clocks to wait for any byte-done before abort.
REQ-004 SHALL have one clock and an asynchronous active-high reset, so all state clears immediately on reset assertion regardless of clock.
REQ-005 SHALL have port I_clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-006 SHALL have port I_rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port I_start, input, 1 bit: request a register access; sampled only in IDLE.
REQ-008 SHALL have port I_rw, input, 1 bit: 1 = read, 0 = write; captured with I_start.
REQ-009 SHALL have port I_addr, input, 7 bits: register address; captured with I_start.
REQ-010 SHALL have port I_wdata, input, 8 bits: write data; captured with I_start.
REQ-011 SHALL have port O_busy, output, 1 bit: high from accept until the O_done cycle, inclusive.
REQ-012 SHALL have port O_done, output, 1 bit: one-clock completion pulse.
REQ-013 SHALL have port O_err, output, 1 bit: one-clock pulse coincident with O_done on timeout abort.
REQ-014 SHALL have port O_rdata, output, 8 bits: read result, valid from O_done until the next accepted read.
REQ-015 SHALL have port O_cs, output, 1 bit: chip-select level to the byte engine; active low.
REQ-016 SHALL have port O_tx_en, output, 1 bit: byte-engine transmit launch, one-clock high pulse.
REQ-017 SHALL have port O_rx_en, output, 1 bit: byte-engine receive launch, one-clock high pulse.
REQ-018 SHALL have port O_tx_byte, output, 8 bits: byte to the engine; held stable from launch until its done.
REQ-019 SHALL have port I_tx_done, input, 1 bit: engine transmit-done level.
REQ-020 SHALL have port I_rx_done, input, 1 bit: engine receive-done level.
REQ-021 SHALL have port I_rx_byte, input, 8 bits: engine received byte, valid while I_rx_done is high.

Function
REQ-022 SHALL implement the states IDLE, SETUP, LAUNCH, WAIT_LO, WAIT_HI, HOLD and FIN.
- IDLE: enter SETUP when I_start=1.
- SETUP: O_cs=0; stay CS_SETUP clocks.
- LAUNCH: one-clock O_tx_en or O_rx_en pulse.
- WAIT_LO: wait until the selected done input is 0.
- WAIT_HI: wait until the selected done input is 1.
- HOLD: stay CS_HOLD clocks, O_cs still 0.
- FIN: O_cs=1, O_done=1; return to IDLE next clock.
REQ-023 SHALL, when a request is accepted in IDLE, latch I_rw, I_addr and I_wdata, set O_busy=1 and drive O_cs=0 on the next clock.
REQ-024 SHALL form byte 0 as {rw, addr[6:0]} and send it via O_tx_en.
REQ-025 SHALL, for a write, send latched wdata via O_tx_en as byte 1.
REQ-026 SHALL, for a read, launch byte 1 via O_rx_en and capture I_rx_byte into O_rdata on the clock it observes I_rx_done=1.
REQ-027 SHALL make WAIT_LO mandatory, because engine done levels stay high after the previous byte; a done seen high without a prior low SHALL NOT complete a byte.
REQ-028 SHALL use WAIT_HI on the last byte to proceed to HOLD, and on the other byte to return to LAUNCH for the next byte.
REQ-029 SHALL never assert O_tx_en and O_rx_en in the same clock, and never launch while O_cs=1.
REQ-030 SHALL run a timeout counter that restarts at each LAUNCH; if it reaches TIMEOUT in WAIT_LO or WAIT_HI, go to FIN with O_err=1 and leave O_rdata unchanged.
REQ-031 SHALL ignore I_start whenever the state is not IDLE; no queuing.
REQ-032 SHALL accept I_start held high across FIN as a new request on the first IDLE clock.
REQ-033 SHALL keep O_tx_byte at its last value outside transfers.

Reset
REQ-034 SHALL, while I_rst=1, force state IDLE, O_cs=1, O_tx_en=0, O_rx_en=0, O_busy=0, O_done=0, O_err=0, O_rdata=0, O_tx_byte=0 and counters 0.
REQ-035 SHALL, on reset mid-transfer, deassert O_cs asynchronously, issue no O_done and discard the request.

Verification
REQ-036 SHALL pass: write, addr=0x12, wdata=0xA5 -> O_tx_byte 0x12 then 0xA5, two O_tx_en pulses, one O_done, O_err=0.
REQ-037 SHALL pass: read, addr=0x05, engine model returns 0x3C -> O_tx_byte 0x85, one O_tx_en then one O_rx_en, O_rdata=0x3C at O_done.
REQ-038 SHALL pass: I_tx_done held at 1 from a prior byte when byte 1 launches -> no early advance; completion only after done goes 0 then 1.
REQ-039 SHALL pass: engine never raises done, TIMEOUT=255 -> O_done and O_err pulse together 256 clocks after LAUNCH, O_cs=1 next clock.
REQ-040 SHALL pass: I_rst pulsed during the second byte -> O_cs=1 immediately, no O_done, next I_start runs normally.
REQ-041 SHALL pass: I_start held high continuously -> back-to-back transfers, O_cs high for at least one clock between them.

Source files
------------

// File: rtl/spi_reg_seq_if.sv
// Request and byte-engine signals of the register-access sequencer.
// slave is the sequencer's view; master is the host/engine side that drives the I_* inputs.
interface spi_reg_seq_if;
    logic       I_start;
    logic       I_rw;
    logic [6:0] I_addr;
    logic [7:0] I_wdata;
    logic       O_busy;
    logic       O_done;
    logic       O_err;
    logic [7:0] O_rdata;
    logic       O_cs;
    logic       O_tx_en;
    logic       O_rx_en;
    logic [7:0] O_tx_byte;
    logic       I_tx_done;
    logic       I_rx_done;
    logic [7:0] I_rx_byte;

    modport slave (
        input  I_start, I_rw, I_addr, I_wdata,
        output O_busy, O_done, O_err, O_rdata,
        output O_cs, O_tx_en, O_rx_en, O_tx_byte,
        input  I_tx_done, I_rx_done, I_rx_byte
    );

    modport master (
        output I_start, I_rw, I_addr, I_wdata,
        input  O_busy, O_done, O_err, O_rdata,
        input  O_cs, O_tx_en, O_rx_en, O_tx_byte,
        output I_tx_done, I_rx_done, I_rx_byte
    );
endinterface

// File: rtl/spi_reg_seq.sv
// Two-byte SPI register access (command byte, then data byte) sequenced around an external byte engine.
// Takes CS_SETUP + engine time + CS_HOLD + 2 clocks; I_start is ignored while busy, with no queuing.
module spi_reg_seq #(
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic         I_clk,
    input  logic         I_rst,
    spi_reg_seq_if.slave bus
);
    localparam int PMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int PW   = (PMAX < 2) ? 1 : $clog2(PMAX);
    localparam int TW   = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        LAUNCH  = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4,
        HOLD    = 3'd5,
        FIN     = 3'd6
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          rw_q;
    logic [6:0]    addr_q;
    logic [7:0]    wdata_q;
    logic          byte_idx_q;
    logic          err_q;
    logic [PW-1:0] phase_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    rdata_q;
    logic [7:0]    tx_byte_q;

    logic rx_phase;
    logic sel_done;
    logic tmo_hit;
    logic setup_last;
    logic hold_last;
    logic in_wait;

    // Only the data byte of a read goes through the receive side of the engine.
    assign rx_phase   = byte_idx_q & rw_q;
    assign sel_done   = rx_phase ? bus.I_rx_done : bus.I_tx_done;
    assign tmo_hit    = (tmo_cnt >= TW'(TIMEOUT));
    assign setup_last = (CS_SETUP <= 1) || (phase_cnt >= PW'(CS_SETUP - 1));
    assign hold_last  = (CS_HOLD <= 1) || (phase_cnt >= PW'(CS_HOLD - 1));
    assign in_wait    = (state_q == WAIT_LO) || (state_q == WAIT_HI);

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A byte completes only on a done low-to-high sequence; a completed done beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.I_start) state_d = SETUP;
            end
            SETUP: begin
                if (setup_last) state_d = LAUNCH;
            end
            LAUNCH: begin
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!sel_done)    state_d = WAIT_HI;
                else if (tmo_hit) state_d = FIN;
            end
            WAIT_HI: begin
                if (sel_done)     state_d = byte_idx_q ? HOLD : LAUNCH;
                else if (tmo_hit) state_d = FIN;
            end
            HOLD: begin
                if (hold_last) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.O_busy  = (state_q != IDLE);
        bus.O_done  = (state_q == FIN);
        bus.O_err   = (state_q == FIN) && err_q;
        bus.O_cs    = !((state_q == SETUP)   || (state_q == LAUNCH) ||
                        (state_q == WAIT_LO) || (state_q == WAIT_HI) ||
                        (state_q == HOLD));
        bus.O_tx_en = (state_q == LAUNCH) && !rx_phase;
        bus.O_rx_en = (state_q == LAUNCH) && rx_phase;
    end

    assign bus.O_rdata   = rdata_q;
    assign bus.O_tx_byte = tx_byte_q;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            rw_q       <= 1'b0;
            addr_q     <= 7'd0;
            wdata_q    <= 8'd0;
            byte_idx_q <= 1'b0;
            err_q      <= 1'b0;
            phase_cnt  <= '0;
            tmo_cnt    <= '0;
            rdata_q    <= 8'd0;
            tx_byte_q  <= 8'd0;
        end else begin
            if ((state_q == IDLE) && bus.I_start) begin
                rw_q       <= bus.I_rw;
                addr_q     <= bus.I_addr;
                wdata_q    <= bus.I_wdata;
                byte_idx_q <= 1'b0;
                err_q      <= 1'b0;
            end

            if (state_d != state_q) begin
                phase_cnt <= '0;
            end else if ((state_q == SETUP) || (state_q == HOLD)) begin
                phase_cnt <= phase_cnt + 1'b1;
            end

            // Starting at 1 in LAUNCH makes the FIN clock land exactly TIMEOUT+1 clocks after LAUNCH.
            if (state_q == LAUNCH) begin
                tmo_cnt <= TW'(1);
            end else if (in_wait && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (in_wait && (state_d == FIN)) begin
                err_q <= 1'b1;
            end

            if ((state_q == WAIT_HI) && sel_done) begin
                if (!byte_idx_q) byte_idx_q <= 1'b1;
                if (rx_phase)    rdata_q    <= bus.I_rx_byte;
            end

            // The read data byte is clocked in, so the command byte stays on O_tx_byte.
            if (state_d == LAUNCH) begin
                if (state_q == SETUP) tx_byte_q <= {rw_q, addr_q};
                else if (!rw_q)       tx_byte_q <= wdata_q;
            end
        end
    end

    a_launch_exclusive : assert property (@(posedge I_clk) disable iff (I_rst)
        !(bus.O_tx_en && bus.O_rx_en));
    a_launch_under_cs : assert property (@(posedge I_clk) disable iff (I_rst)
        (bus.O_tx_en || bus.O_rx_en) |-> !bus.O_cs);
    a_done_then_idle : assert property (@(posedge I_clk) disable iff (I_rst)
        bus.O_done |=> !bus.O_busy);
endmodule

// File: tb/tb_spi_reg_seq.sv
// Directed bench for spi_reg_seq with a simple byte-engine model (done drops 2 clocks after launch, rises 3 later).
module tb_spi_reg_seq;
    logic clk = 1'b0;
    logic rst;

    spi_reg_seq_if bus();

    spi_reg_seq #(
        .CS_SETUP(4),
        .CS_HOLD (4),
        .TIMEOUT (255)
    ) dut (
        .I_clk(clk),
        .I_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         n_tx = 0;
    int         n_rx = 0;
    int         n_done = 0;
    int         n_err = 0;
    int         n_viol = 0;
    logic [7:0] launch_seq = 8'd0;
    time        t_launch = 0;
    logic [7:0] tx_log[$];
    logic       eng_respond = 1'b1;
    logic [7:0] eng_rx_val = 8'd0;
    logic       busy_at_start;
    logic       cs_at_start;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] log_back(input int back);
        if (tx_log.size() < back) return 32'hFFFF_FFFF;
        return 32'(tx_log[tx_log.size() - back]);
    endfunction

    // Byte engine: done levels stay high between bytes, as a real engine's do.
    initial begin : engine
        int   cnt;
        logic eng_busy;
        logic is_rx;
        cnt      = 0;
        eng_busy = 1'b0;
        is_rx    = 1'b0;
        bus.I_tx_done = 1'b1;
        bus.I_rx_done = 1'b1;
        bus.I_rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (eng_busy) begin
                cnt++;
                if (cnt == 2) begin
                    if (is_rx) begin
                        bus.I_rx_done = 1'b0;
                        bus.I_rx_byte = 8'hEE;
                    end else begin
                        bus.I_tx_done = 1'b0;
                    end
                end
                if (cnt == 5 && eng_respond) begin
                    if (is_rx) begin
                        bus.I_rx_byte = eng_rx_val;
                        bus.I_rx_done = 1'b1;
                    end else begin
                        bus.I_tx_done = 1'b1;
                    end
                    eng_busy = 1'b0;
                end
            end
            if (bus.O_tx_en || bus.O_rx_en) begin
                eng_busy = 1'b1;
                cnt      = 0;
                is_rx    = bus.O_rx_en;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.O_tx_en) begin
                n_tx++;
                tx_log.push_back(bus.O_tx_byte);
            end
            if (bus.O_rx_en) n_rx++;
            if (bus.O_tx_en || bus.O_rx_en) begin
                launch_seq = {launch_seq[6:0], bus.O_rx_en};
                t_launch   = $time;
                if (bus.O_cs || (bus.O_tx_en && bus.O_rx_en)) n_viol++;
            end
            if (bus.O_done) n_done++;
            if (bus.O_err)  n_err++;
        end
    end

    task automatic run_xfer(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                            output int lat, output logic to);
        bus.I_start = 1'b1;
        bus.I_rw    = rw;
        bus.I_addr  = addr;
        bus.I_wdata = wd;
        step();
        bus.I_start   = 1'b0;
        busy_at_start = bus.O_busy;
        cs_at_start   = bus.O_cs;
        lat = 0;
        while (!bus.O_done && lat < 2000) begin
            step();
            lat++;
        end
        to = !bus.O_done;
    endtask

    initial begin : main
        int   lat;
        int   k;
        int   g;
        logic to;
        int   b_tx;
        int   b_rx;
        int   b_done;
        int   b_err;

        bus.I_start = 1'b0;
        bus.I_rw    = 1'b0;
        bus.I_addr  = 7'd0;
        bus.I_wdata = 8'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        step();

        chk("rst_cs",      32'(bus.O_cs),      1);
        chk("rst_busy",    32'(bus.O_busy),    0);
        chk("rst_done",    32'(bus.O_done),    0);
        chk("rst_err",     32'(bus.O_err),     0);
        chk("rst_tx_en",   32'(bus.O_tx_en),   0);
        chk("rst_rx_en",   32'(bus.O_rx_en),   0);
        chk("rst_rdata",   32'(bus.O_rdata),   0);
        chk("rst_tx_byte", 32'(bus.O_tx_byte), 0);

        rst = 1'b0;
        step();
        step();

        // Write 0x12 <- 0xA5: accept, 4 setup, 2 x (launch + 2 high + 3 low), 4 hold -> FIN 20 clocks after SETUP starts.
        b_tx = n_tx; b_rx = n_rx; b_done = n_done;
        run_xfer(1'b0, 7'h12, 8'hA5, lat, to);
        chk("wr_busy_start", 32'(busy_at_start), 1);
        chk("wr_cs_start",   32'(cs_at_start),   0);
        chk("wr_latency",    lat,                20);
        chk("wr_err",        32'(bus.O_err),     0);
        chk("wr_cs_at_done", 32'(bus.O_cs),      1);
        chk("wr_busy_done",  32'(bus.O_busy),    1);
        step();
        chk("wr_done_cnt",   n_done - b_done,    1);
        chk("wr_tx_cnt",     n_tx - b_tx,        2);
        chk("wr_rx_cnt",     n_rx - b_rx,        0);
        chk("wr_byte0",      log_back(2),        'h12);
        chk("wr_byte1",      log_back(1),        'hA5);
        chk("wr_busy_after", 32'(bus.O_busy),    0);
        step();
        step();
        chk("wr_tx_byte_hold", 32'(bus.O_tx_byte), 'hA5);

        // Read 0x05 -> 0x3C
        eng_rx_val = 8'h3C;
        b_tx = n_tx; b_rx = n_rx; b_done = n_done;
        run_xfer(1'b1, 7'h05, 8'h00, lat, to);
        chk("rd_latency",  lat,                20);
        chk("rd_rdata",    32'(bus.O_rdata),   'h3C);
        chk("rd_err",      32'(bus.O_err),     0);
        step();
        chk("rd_tx_cnt",   n_tx - b_tx,        1);
        chk("rd_rx_cnt",   n_rx - b_rx,        1);
        chk("rd_order",    32'(launch_seq[1:0]), 'b01);
        chk("rd_cmd_byte", log_back(1),        'h85);
        chk("rd_tx_byte",  32'(bus.O_tx_byte), 'h85);
        chk("rd_done_cnt", n_done - b_done,    1);
        step();
        step();

        // Engine drops done but never raises it again: abort 256 clocks after LAUNCH.
        eng_respond = 1'b0;
        b_done = n_done; b_err = n_err;
        run_xfer(1'b1, 7'h33, 8'h00, lat, to);
        chk("to_reached_done",    32'(to), 0);
        chk("to_launch_to_done",  int'(($time - t_launch) / 10), 256);
        chk("to_err",             32'(bus.O_err),   1);
        chk("to_rdata_kept",      32'(bus.O_rdata), 'h3C);
        step();
        chk("to_cs_after",        32'(bus.O_cs),    1);
        chk("to_done_after",      32'(bus.O_done),  0);
        chk("to_err_after",       32'(bus.O_err),   0);
        chk("to_done_cnt",        n_done - b_done,  1);
        chk("to_err_cnt",         n_err - b_err,    1);
        eng_respond = 1'b1;
        step();

        // Reset pulse during the data byte, between clock edges.
        b_tx = n_tx; b_done = n_done;
        bus.I_start = 1'b1;
        bus.I_rw    = 1'b0;
        bus.I_addr  = 7'h40;
        bus.I_wdata = 8'h11;
        step();
        bus.I_start = 1'b0;
        k = 0;
        while ((n_tx - b_tx) < 2 && k < 500) begin
            step();
            k++;
        end
        chk("rst_mid_reached_byte1", n_tx - b_tx, 2);
        step();
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_cs",      32'(bus.O_cs),      1);
        chk("rst_mid_busy",    32'(bus.O_busy),    0);
        chk("rst_mid_tx_byte", 32'(bus.O_tx_byte), 0);
        chk("rst_mid_rdata",   32'(bus.O_rdata),   0);
        step();
        rst = 1'b0;
        repeat (30) step();
        chk("rst_mid_no_done", n_done - b_done,    0);
        chk("rst_mid_idle",    32'(bus.O_busy),    0);

        run_xfer(1'b0, 7'h7F, 8'h5A, lat, to);
        chk("post_rst_done",  32'(to),           0);
        chk("post_rst_err",   32'(bus.O_err),    0);
        step();
        chk("post_rst_byte0", log_back(2),       'h7F);
        chk("post_rst_byte1", log_back(1),       'h5A);
        step();

        // I_start held high: two back-to-back writes with CS high in FIN and IDLE between them.
        b_done = n_done;
        bus.I_start = 1'b1;
        bus.I_rw    = 1'b0;
        bus.I_addr  = 7'h21;
        bus.I_wdata = 8'h99;
        k = 0;
        while (!bus.O_done && k < 500) begin
            step();
            k++;
        end
        chk("b2b_first_done", 32'(bus.O_done), 1);
        g = 0;
        while (bus.O_cs && g < 50) begin
            step();
            g++;
        end
        chk("b2b_cs_gap", g, 2);
        k = 0;
        while (!bus.O_done && k < 500) begin
            step();
            k++;
        end
        chk("b2b_second_done", 32'(bus.O_done), 1);
        bus.I_start = 1'b0;
        repeat (6) step();
        chk("b2b_done_cnt", n_done - b_done,  2);
        chk("b2b_idle",     32'(bus.O_busy),  0);
        chk("b2b_last_byte", log_back(1),     'h99);

        chk("launch_rules", n_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end
endmodule
